// File: rtl/pulse_divider_pkg.sv
// -----------------------------------------------------------------------------
// pulse_divider_pkg
// Shared constants for the pulse divider block.
//   MODE_PULSE  - channel output is a one-cycle pulse on every wrap
//   MODE_SQUARE - channel output toggles on every wrap (50% duty square wave)
//   DEFAULT_DIV - reset divisor; 50 MHz / 50_000_000 gives a 1 Hz tick
// -----------------------------------------------------------------------------
package pulse_divider_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    localparam int unsigned DEFAULT_DIV = 50_000_000;

endpackage : pulse_divider_pkg

// File: rtl/pulse_div_ch.sv
// -----------------------------------------------------------------------------
// pulse_div_ch
// One divider channel: counts enabled cycles modulo an active divisor D and
// emits a registered wrap strobe (tick) plus a mode-dependent output (y).
// A new divisor is staged in a pending register and only becomes active on a
// wrap, or straight away while the channel is disabled.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   en      in   channel enable; low holds the counter at 0 and outputs at 0
//   mode    in   MODE_PULSE / MODE_SQUARE, sampled at each wrap
//   clr     in   synchronous clear of counter and outputs (divisors kept)
//   wr      in   divisor write strobe, already decoded for this channel
//   wr_val  in   divisor value written by wr
//   y       out  registered channel output
//   tick    out  registered one-cycle strobe following every wrap
// -----------------------------------------------------------------------------
module pulse_div_ch
    import pulse_divider_pkg::*;
#(
    parameter int          DIV_W   = 32,
    parameter int unsigned DEF_DIV = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_val,
    output logic             y,
    output logic             tick
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             mode_q, mode_d;
    logic             y_q, y_d;
    logic             tick_q, tick_d;
    // Goes high on the first clock after reset release, so counting starts
    // on the second rising edge after deassertion.
    logic             run_q;

    logic [DIV_W-1:0] div_last;
    logic             at_last;

    // A divisor of 0 behaves like 1; clamping before the subtraction keeps
    // the terminal count from underflowing to all-ones.
    assign div_last = (div_q == '0) ? '0 : (div_q - ONE);
    assign at_last  = (cnt_q == div_last);

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        mode_d     = mode_q;
        y_d        = y_q;
        tick_d     = 1'b0;

        // The pending value always tracks the latest write; only the pending
        // flag and the promotion into the active divisor depend on state.
        if (wr) begin
            pend_val_d = wr_val;
        end

        if (clr) begin
            // Clear wins over a wrap; divisors and pending state survive.
            cnt_d = '0;
            y_d   = 1'b0;
            if (wr) begin
                pend_d = 1'b1;
            end
        end else if (!en) begin
            // Idle channel: no period in flight, so a divisor can apply now.
            cnt_d  = '0;
            y_d    = 1'b0;
            mode_d = mode;
            if (wr) begin
                div_d  = wr_val;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = pend_val_q;
                pend_d = 1'b0;
            end
        end else if (!run_q) begin
            if (wr) begin
                pend_d = 1'b1;
            end
        end else if (at_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            mode_d = mode;
            y_d    = (mode == MODE_PULSE) ? 1'b1 : ~y_q;
            // A write landing on the wrap cycle governs the next period.
            if (wr) begin
                div_d  = wr_val;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = pend_val_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + ONE;
            if (mode_q == MODE_PULSE) begin
                y_d = 1'b0;
            end
            if (wr) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            pend_val_q <= RST_DIV;
            pend_q     <= 1'b0;
            mode_q     <= MODE_PULSE;
            y_q        <= 1'b0;
            tick_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            mode_q     <= mode_d;
            y_q        <= y_d;
            tick_q     <= tick_d;
            run_q      <= 1'b1;
        end
    end

    assign y    = y_q;
    assign tick = tick_q;

endmodule : pulse_div_ch

// File: rtl/pulse_divider.sv
// -----------------------------------------------------------------------------
// pulse_divider
// NUM_CH independent programmable clock-enable dividers. The top only decodes
// the divisor write port and gathers the per-channel outputs.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   en       in   [NUM_CH]  per-channel enable
//   mode     in   [NUM_CH]  per-channel mode (0 pulse, 1 square)
//   clr      in   synchronous clear of all counters and outputs
//   div_wr   in   divisor write strobe
//   div_ch   in   [CH_W]    target channel; values >= NUM_CH are ignored
//   div_val  in   [DIV_W]   divisor value
//   y        out  [NUM_CH]  per-channel registered output
//   tick     out  [NUM_CH]  per-channel one-cycle wrap strobe
// -----------------------------------------------------------------------------
module pulse_divider
    import pulse_divider_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          DIV_W   = 32,
    parameter int unsigned DEF_DIV = DEFAULT_DIV,
    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              clr,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_val,
    output logic [NUM_CH-1:0] y,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] wr_hit;

    // An out-of-range div_ch matches no generated index, so it is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_hit[gi] = div_wr && (div_ch == CH_W'(gi));

            pulse_div_ch #(
                .DIV_W   (DIV_W),
                .DEF_DIV (DEF_DIV)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .en     (en[gi]),
                .mode   (mode[gi]),
                .clr    (clr),
                .wr     (wr_hit[gi]),
                .wr_val (div_val),
                .y      (y[gi]),
                .tick   (tick[gi])
            );
        end
    endgenerate

endmodule : pulse_divider
